quiz_scoreboard: RTL

QUIZ_SCOREBOARD -- requirements
Module: quiz_scoreboard

---
 rtl/quiz_pkg.sv | 14 +
 rtl/quiz_answer_timer.sv | 26 ++
 rtl/quiz_scoreboard.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/quiz_pkg.sv
// Shared types and constants for the quiz buzzer scoreboard.
package quiz_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_ANSWER = 2'd2
    } state_t;

    localparam int NUM_PLAYERS = 4;
    localparam int CORRECT_PTS = 2;
    localparam int WRONG_PTS   = 1;

endpackage

// File: rtl/quiz_answer_timer.sv
// Loadable down-counter for the answer window; expired is high while the count is zero.
module quiz_answer_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_enable,
    input  logic [W-1:0] i_value,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_value;
        else if (i_enable && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/quiz_scoreboard.sv
// Four-player buzzer round controller: arms the upstream latch, picks the one-hot
// winner, times the answer and keeps saturating per-player scores.
module quiz_scoreboard
    import quiz_pkg::*;
#(
    parameter int SCORE_W    = 8,
    parameter int ANSWER_CYC = 1000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_round,
    input  logic                         clear_scores,
    input  logic                         lock_valid,
    input  logic [3:0]                   lock_q,
    input  logic                         judge_correct,
    input  logic                         judge_wrong,
    output logic                         rearm,
    output logic                         winner_valid,
    output logic [1:0]                   winner_id,
    output logic                         timeout,
    output logic                         lock_error,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic [1:0]                   state
);

    localparam int TW = (ANSWER_CYC > 1) ? $clog2(ANSWER_CYC) : 1;
    localparam logic [SCORE_W-1:0] MAX_SCORE = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] C_PTS = SCORE_W'(CORRECT_PTS);
    localparam logic [SCORE_W-1:0] W_PTS = SCORE_W'(WRONG_PTS);

    state_t             r_state, w_next;
    logic               r_rearm, r_lock_err, r_timeout;
    logic [1:0]         r_winner;
    logic [SCORE_W-1:0] r_scores [NUM_PLAYERS];

    logic               w_rearm, w_lock_err, w_timeout, w_load, w_clear;
    logic               w_add, w_sub, w_onehot, w_judge, w_expired;
    logic [1:0]         w_enc;
    logic [SCORE_W-1:0] w_cur, w_inc, w_dec;

    assign w_onehot = (lock_q != 4'd0) && ((lock_q & 4'(lock_q - 4'd1)) == 4'd0);
    assign w_judge  = judge_correct | judge_wrong;

    always_comb begin
        w_enc = 2'd0;
        for (int i = 0; i < NUM_PLAYERS; i++)
            if (lock_q[i]) w_enc = 2'(i);
    end

    quiz_answer_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_enable (r_state == S_ANSWER && !w_judge),
        .i_value  (TW'(ANSWER_CYC - 1)),
        .o_expired(w_expired)
    );

    always_comb begin
        w_next     = r_state;
        w_rearm    = 1'b0;
        w_lock_err = 1'b0;
        w_timeout  = 1'b0;
        w_load     = 1'b0;
        w_clear    = 1'b0;
        w_add      = 1'b0;
        w_sub      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_clear = clear_scores;
                if (start_round) begin
                    w_next  = S_ARMED;
                    w_rearm = 1'b1;
                end
            end
            S_ARMED: begin
                if (lock_valid) begin
                    if (w_onehot) begin
                        w_next = S_ANSWER;
                        w_load = 1'b1;
                    end else begin
                        w_lock_err = 1'b1;
                        w_rearm    = 1'b1;
                    end
                end
            end
            S_ANSWER: begin
                // a wrong verdict outranks a simultaneous correct one and the timer
                if (judge_wrong) begin
                    w_sub  = 1'b1;
                    w_next = S_IDLE;
                end else if (judge_correct) begin
                    w_add  = 1'b1;
                    w_next = S_IDLE;
                end else if (w_expired) begin
                    w_sub     = 1'b1;
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rearm    <= 1'b0;
            r_lock_err <= 1'b0;
            r_timeout  <= 1'b0;
            r_winner   <= 2'd0;
        end else begin
            r_state    <= w_next;
            r_rearm    <= w_rearm;
            r_lock_err <= w_lock_err;
            r_timeout  <= w_timeout;
            if (w_load) r_winner <= w_enc;
        end
    end

    assign w_cur = r_scores[r_winner];
    assign w_inc = (w_cur > MAX_SCORE - C_PTS) ? MAX_SCORE : w_cur + C_PTS;
    assign w_dec = (w_cur < W_PTS) ? '0 : w_cur - W_PTS;

    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            for (int i = 0; i < NUM_PLAYERS; i++) r_scores[i] <= '0;
        end else if (w_add) begin
            r_scores[r_winner] <= w_inc;
        end else if (w_sub) begin
            r_scores[r_winner] <= w_dec;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PLAYERS; g++) begin : g_scores
            assign scores[g*SCORE_W +: SCORE_W] = r_scores[g];
        end
    endgenerate

    assign rearm        = r_rearm;
    assign lock_error   = r_lock_err;
    assign timeout      = r_timeout;
    assign winner_id    = r_winner;
    assign winner_valid = (r_state == S_ANSWER);
    assign state        = r_state;

endmodule
